// File: rtl/mem_wb_stage.sv
// Back end of the riscv_core pipeline: EX/MEM register, data memory, MEM/WB register, write-back mux.
// Optional sub-word (B/H/BU/HU) access support is enabled by defining MEM_SUBWORD_EN.
module mem_wb_stage #(
    parameter int DMEM_DEPTH     = 1024,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ex_valid,
    input  logic [DATA_WIDTH-1:0]     ex_alu_result,
    input  logic [DATA_WIDTH-1:0]     ex_rd_data2,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
    input  logic                      ex_RegWrite,
    input  logic                      ex_MemRead,
    input  logic                      ex_MemWrite,
    input  logic [1:0]                ex_WBSel,
    input  logic [2:0]                ex_funct3,
    input  logic [DATA_WIDTH-1:0]     ex_pc_plus4,
    output logic                      WB_RegWrite_w,
    output logic [REG_ADDR_WIDTH-1:0] WB_wr_addr_w,
    output logic [DATA_WIDTH-1:0]     WB_wr_data_w,
    output logic                      mem_misalign_o
);

    // WB_NONE is the all-zero code so that bubbles and reset select zero write data.
    localparam logic [1:0] WB_NONE = 2'd0;
    localparam logic [1:0] WB_ALU  = 2'd1;
    localparam logic [1:0] WB_MEM  = 2'd2;
    localparam logic [1:0] WB_PC4  = 2'd3;
    localparam int         AW      = $clog2(DMEM_DEPTH);

    function automatic logic misaligned_f(input logic [2:0] f3, input logic [1:0] off);
        logic res;
        res = 1'b0;
        case (f3[1:0])
            2'b00:   res = 1'b0;
            2'b01:   res = off[0];
            default: res = (off != 2'b00);
        endcase
        return res;
    endfunction

    function automatic logic [3:0] lane_mask_f(input logic [2:0] f3, input logic [1:0] off);
        logic [3:0] res;
        res = 4'b0000;
        case (f3[1:0])
            2'b00:   res = 4'b0001 << off;
            2'b01:   res = 4'b0011 << off;
            default: res = 4'b1111;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] store_data_f(input logic [2:0] f3, input logic [31:0] data);
        logic [31:0] res;
        res = 32'd0;
        case (f3[1:0])
            2'b00:   res = {4{data[7:0]}};
            2'b01:   res = {2{data[15:0]}};
            default: res = data;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] load_format_f(input logic [2:0] f3, input logic [1:0] off,
                                                  input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] res;
        sh  = word >> {off, 3'b000};
        res = 32'd0;
        case (f3[1:0])
            2'b00:   res = f3[2] ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            2'b01:   res = f3[2] ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

    logic [2:0] ex_f3_eff_s;
`ifdef MEM_SUBWORD_EN
    assign ex_f3_eff_s = ex_funct3;
`else
    // Word-only build: every access behaves as lw/sw.
    logic unused_funct3_s;
    assign ex_f3_eff_s     = 3'b010;
    assign unused_funct3_s = ^ex_funct3;
`endif

    logic                      em_valid_r;
    logic [DATA_WIDTH-1:0]     em_alu_r;
    logic [DATA_WIDTH-1:0]     em_data2_r;
    logic [REG_ADDR_WIDTH-1:0] em_rd_r;
    logic                      em_regwrite_r;
    logic                      em_memread_r;
    logic                      em_memwrite_r;
    logic [1:0]                em_wbsel_r;
    logic [2:0]                em_funct3_r;
    logic [DATA_WIDTH-1:0]     em_pc4_r;

    logic                      mw_valid_r;
    logic [REG_ADDR_WIDTH-1:0] mw_rd_r;
    logic                      mw_regwrite_r;
    logic [1:0]                mw_wbsel_r;
    logic [2:0]                mw_funct3_r;
    logic [DATA_WIDTH-1:0]     mw_alu_r;
    logic [DATA_WIDTH-1:0]     mw_pc4_r;
    logic                      mw_mis_r;

    logic [31:0]   mem_r [DMEM_DEPTH];
    logic [31:0]   rd_word_r;
    logic [AW-1:0] mem_idx_s;
    logic          em_mis_s;
    logic          mem_we_s;
    logic [3:0]    lane_s;
    logic [31:0]   wdata_s;
    logic [31:0]   load_s;

    // EX/MEM pipeline register; a bubble clears valid and all control flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            em_valid_r    <= 1'b0;
            em_alu_r      <= {DATA_WIDTH{1'b0}};
            em_data2_r    <= {DATA_WIDTH{1'b0}};
            em_rd_r       <= {REG_ADDR_WIDTH{1'b0}};
            em_regwrite_r <= 1'b0;
            em_memread_r  <= 1'b0;
            em_memwrite_r <= 1'b0;
            em_wbsel_r    <= WB_NONE;
            em_funct3_r   <= 3'b000;
            em_pc4_r      <= {DATA_WIDTH{1'b0}};
        end else begin
            em_alu_r    <= ex_alu_result;
            em_data2_r  <= ex_rd_data2;
            em_rd_r     <= ex_rd_addr;
            em_funct3_r <= ex_f3_eff_s;
            em_pc4_r    <= ex_pc_plus4;
            if (ex_valid) begin
                em_valid_r    <= 1'b1;
                em_regwrite_r <= ex_RegWrite;
                em_memread_r  <= ex_MemRead;
                em_memwrite_r <= ex_MemWrite;
                em_wbsel_r    <= ex_WBSel;
            end else begin
                em_valid_r    <= 1'b0;
                em_regwrite_r <= 1'b0;
                em_memread_r  <= 1'b0;
                em_memwrite_r <= 1'b0;
                em_wbsel_r    <= WB_NONE;
            end
        end
    end

    // MEM-stage address decode, alignment check and store lane/data formatting
    always_comb begin
        mem_idx_s = em_alu_r[AW+1:2];
        em_mis_s  = em_valid_r & (em_memread_r | em_memwrite_r)
                  & misaligned_f(em_funct3_r, em_alu_r[1:0]);
        mem_we_s  = ~rst & em_valid_r & em_memwrite_r & ~em_mis_s;
        lane_s    = lane_mask_f(em_funct3_r, em_alu_r[1:0]);
        wdata_s   = store_data_f(em_funct3_r, em_data2_r);
    end

    // Data memory: byte-lane write and synchronous read on the same closing edge
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_s[b]) begin
                    mem_r[mem_idx_s][8*b +: 8] <= wdata_s[8*b +: 8];
                end
            end
        end
        rd_word_r <= mem_r[mem_idx_s];
    end

    // MEM/WB pipeline register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mw_valid_r    <= 1'b0;
            mw_rd_r       <= {REG_ADDR_WIDTH{1'b0}};
            mw_regwrite_r <= 1'b0;
            mw_wbsel_r    <= WB_NONE;
            mw_funct3_r   <= 3'b000;
            mw_alu_r      <= {DATA_WIDTH{1'b0}};
            mw_pc4_r      <= {DATA_WIDTH{1'b0}};
            mw_mis_r      <= 1'b0;
        end else begin
            mw_valid_r    <= em_valid_r;
            mw_rd_r       <= em_rd_r;
            mw_regwrite_r <= em_regwrite_r;
            mw_wbsel_r    <= em_wbsel_r;
            mw_funct3_r   <= em_funct3_r;
            mw_alu_r      <= em_alu_r;
            mw_pc4_r      <= em_pc4_r;
            mw_mis_r      <= em_mis_s;
        end
    end

    // Write-back data select and register-file write enable
    always_comb begin
        load_s        = load_format_f(mw_funct3_r, mw_alu_r[1:0], rd_word_r);
        WB_wr_data_w  = {DATA_WIDTH{1'b0}};
        case (mw_wbsel_r)
            WB_ALU:  WB_wr_data_w = mw_alu_r;
            WB_MEM:  WB_wr_data_w = load_s;
            WB_PC4:  WB_wr_data_w = mw_pc4_r;
            default: WB_wr_data_w = {DATA_WIDTH{1'b0}};
        endcase
        WB_wr_addr_w   = mw_rd_r;
        WB_RegWrite_w  = mw_valid_r & mw_regwrite_r & ~mw_mis_r
                       & (mw_rd_r != {REG_ADDR_WIDTH{1'b0}});
        mem_misalign_o = mw_valid_r & mw_mis_r;
    end

endmodule
